// File: rtl/spike_pkg.sv
// Shared types and defaults for the spike-rate decoder slice.
package spike_pkg;

  localparam int unsigned NCH        = 4;
  localparam int unsigned WINDOW_DEF = 15;
  localparam int unsigned CW_DEF     = 4;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result bus of the spike-rate decoder: four counts, saturation flags,
// valid/ready handshake and the sticky overrun flag.
interface spike_rate_decoder_if
  import spike_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
);

  logic [CW-1:0]  cnt1;
  logic [CW-1:0]  cnt2;
  logic [CW-1:0]  cnt3;
  logic [CW-1:0]  cnt4;
  logic [NCH-1:0] sat;
  logic           out_valid;
  logic           out_ready;
  logic           overrun;

  modport master (
    output cnt1, cnt2, cnt3, cnt4, sat, out_valid, overrun,
    input  out_ready
  );

  modport slave (
    input  cnt1, cnt2, cnt3, cnt4, sat, out_valid, overrun,
    output out_ready
  );

endinterface

// File: rtl/spike_acc_channel.sv
// One saturating spike accumulator plus its overflow bit. The outputs are
// the next values (stored value with this edge's spike applied), which the
// top latches directly at window close.
module spike_acc_channel
  import spike_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] acc,
  output logic          sat_bit
);

  logic [CW-1:0] acc_q;
  logic          sat_q;
  logic          full;

  // Saturating next value: an increment at full scale only raises the sat bit.
  always_comb begin
    full    = &acc_q;
    acc     = (inc && !full) ? acc_q + CW'(1) : acc_q;
    sat_bit = sat_q | (inc & full);
  end

  // Accumulator register; clr discards the window (en low or window close).
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc;
      sat_q <= sat_bit;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Four-channel spike-count decoder: counts spikes per channel over WINDOW
// enabled cycles and presents saturating counts over a valid/ready bus.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned CW     = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH-1:0]       spikes,
  spike_rate_decoder_if.master bus
);

  localparam logic [7:0] LAST = 8'(WINDOW - 1);

  state_t         state;
  logic [7:0]     win_cnt;
  logic           close;
  logic           clr;
  logic [CW-1:0]  fin [NCH];
  logic [NCH-1:0] fin_sat;

  // Window closes on the enabled edge that carries sample WINDOW-1.
  always_comb begin
    close = en && (win_cnt == LAST);
    clr   = !en || close;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    spike_acc_channel #(.CW(CW)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .inc     (en & spikes[i]),
      .acc     (fin[i]),
      .sat_bit (fin_sat[i])
    );
  end

  // FSM, window counter, result registers, handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      win_cnt       <= '0;
      bus.cnt1      <= '0;
      bus.cnt2      <= '0;
      bus.cnt3      <= '0;
      bus.cnt4      <= '0;
      bus.sat       <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state   <= COUNT;
            win_cnt <= close ? 8'd0 : 8'd1;
          end else begin
            win_cnt <= '0;
          end
        end
        COUNT: begin
          if (!en) begin
            state   <= IDLE;
            win_cnt <= '0;
          end else begin
            win_cnt <= close ? 8'd0 : win_cnt + 8'd1;
          end
        end
      endcase

      if (close && (!bus.out_valid || bus.out_ready)) begin
        bus.cnt1      <= fin[0];
        bus.cnt2      <= fin[1];
        bus.cnt3      <= fin[2];
        bus.cnt4      <= fin[3];
        bus.sat       <= fin_sat;
        bus.out_valid <= 1'b1;
      end else if (close) begin
        bus.overrun   <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder at WINDOW = 15, 20, 4 and 1.
module tb_spike_rate_decoder;
  import spike_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en15 = 0, en20 = 0, en4 = 0, en1 = 0;
  logic [3:0] sp15 = 0, sp20 = 0, sp4 = 0, sp1 = 0;

  spike_rate_decoder_if #(.CW(4)) b15 ();
  spike_rate_decoder_if #(.CW(4)) b20 ();
  spike_rate_decoder_if #(.CW(4)) b4 ();
  spike_rate_decoder_if #(.CW(4)) b1 ();

  spike_rate_decoder #(.WINDOW(15), .CW(4)) u15 (.clk(clk), .rst_n(rst_n), .en(en15), .spikes(sp15), .bus(b15));
  spike_rate_decoder #(.WINDOW(20), .CW(4)) u20 (.clk(clk), .rst_n(rst_n), .en(en20), .spikes(sp20), .bus(b20));
  spike_rate_decoder #(.WINDOW(4),  .CW(4)) u4  (.clk(clk), .rst_n(rst_n), .en(en4),  .spikes(sp4),  .bus(b4));
  spike_rate_decoder #(.WINDOW(1),  .CW(4)) u1  (.clk(clk), .rst_n(rst_n), .en(en1),  .spikes(sp1),  .bus(b1));

  // Packed view {valid, overrun, sat, cnt4, cnt3, cnt2, cnt1}
  logic [21:0] o15, o20, o4, o1;
  assign o15 = {b15.out_valid, b15.overrun, b15.sat, b15.cnt4, b15.cnt3, b15.cnt2, b15.cnt1};
  assign o20 = {b20.out_valid, b20.overrun, b20.sat, b20.cnt4, b20.cnt3, b20.cnt2, b20.cnt1};
  assign o4  = {b4.out_valid,  b4.overrun,  b4.sat,  b4.cnt4,  b4.cnt3,  b4.cnt2,  b4.cnt1};
  assign o1  = {b1.out_valid,  b1.overrun,  b1.sat,  b1.cnt4,  b1.cnt3,  b1.cnt2,  b1.cnt1};

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic        en;
    logic [3:0]  spk;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [21:0] pk(logic v, logic ov, logic [3:0] s,
                                     logic [3:0] c1, logic [3:0] c2,
                                     logic [3:0] c3, logic [3:0] c4);
    return {v, ov, s, c4, c3, c2, c1};
  endfunction

  task automatic check(input string nm, input logic [21:0] got, input logic [21:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got v=%b ov=%b sat=%b cnt4..1=%h required v=%b ov=%b sat=%b cnt4..1=%h",
               nm, got[21], got[20], got[19:16], got[15:0], exp[21], exp[20], exp[19:16], exp[15:0]);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en15 = 0; en20 = 0; en4 = 0; en1 = 0;
    sp15 = 0; sp20 = 0; sp4 = 0; sp1 = 0;
    b15.out_ready = 0; b20.out_ready = 0; b4.out_ready = 0; b1.out_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      en15 = 1'($urandom); en20 = 1'($urandom); en4 = 1'($urandom); en1 = 1'($urandom);
      sp15 = 4'($urandom); sp20 = 4'($urandom); sp4 = 4'($urandom); sp1 = 4'($urandom);
      b15.out_ready = 1'($urandom); b20.out_ready = 1'($urandom);
      b4.out_ready  = 1'($urandom); b1.out_ready  = 1'($urandom);
      step();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);

    // Reset state of every instance
    do_reset();
    check("reset_w15", o15, '0);
    check("reset_w20", o20, '0);
    check("reset_w4",  o4,  '0);
    check("reset_w1",  o1,  '0);

    // Pattern table: ch1 always, ch2 even samples, ch3 never, ch4 sample 14
    for (int s = 0; s < 15; s++) begin
      tbl[s].en  = 1'b1;
      tbl[s].spk = {s == 14, 1'b0, (s % 2) == 0, 1'b1};
      tbl[s].rdy = 1'b0;
      tbl[s].exp = (s == 14) ? pk(1, 0, 4'b0000, 15, 8, 0, 1) : '0;
    end
    tbl[15].en = 1'b1; tbl[15].spk = 4'b0000; tbl[15].rdy = 1'b1;
    tbl[15].exp = pk(0, 0, 4'b0000, 15, 8, 0, 1);
    tbl[16].en = 1'b0; tbl[16].spk = 4'b1111; tbl[16].rdy = 1'b1;
    tbl[16].exp = pk(0, 0, 4'b0000, 15, 8, 0, 1);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      en15 = tbl[i].en; sp15 = tbl[i].spk; b15.out_ready = tbl[i].rdy;
      step();
      check($sformatf("pattern[%0d]", i), o15, tbl[i].exp);
    end

    // Full rate, two consecutive windows
    do_reset();
    en15 = 1; sp15 = 4'hf; b15.out_ready = 1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 14) check("full_pre_close", o15, '0);
      if (i == 15) check("full_win1", o15, pk(1, 0, 0, 15, 15, 15, 15));
      if (i == 16) check("full_consumed", o15, pk(0, 0, 0, 15, 15, 15, 15));
      if (i == 30) check("full_win2", o15, pk(1, 0, 0, 15, 15, 15, 15));
    end

    // Saturation over a 20-cycle window
    do_reset();
    en20 = 1; sp20 = 4'b0101;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 19) check("sat_pre_close", o20, '0);
      if (i == 20) check("sat_result", o20, pk(1, 0, 4'b0101, 15, 0, 15, 0));
    end

    // Backpressure and overrun
    do_reset();
    en4 = 1; sp4 = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    check("bp_win1", o4, pk(1, 0, 0, 4, 0, 0, 0));
    sp4 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_hold[%0d]", i), o4, pk(1, 0, 0, 4, 0, 0, 0));
    end
    step();
    check("bp_overrun", o4, pk(1, 1, 0, 4, 0, 0, 0));
    b4.out_ready = 1;
    step();
    b4.out_ready = 0;
    check("bp_consumed", o4, pk(0, 1, 0, 4, 0, 0, 0));
    for (int i = 0; i < 3; i++) step();
    check("bp_win3", o4, pk(1, 1, 0, 0, 0, 0, 0));

    // Enable drop discards the partial window
    do_reset();
    en15 = 1; sp15 = 4'hf; b15.out_ready = 1;
    for (int i = 0; i < 7; i++) step();
    en15 = 0;
    for (int i = 0; i < 3; i++) step();
    en15 = 1;
    for (int i = 0; i < 14; i++) step();
    check("en_pre_close", o15, '0);
    step();
    check("en_result", o15, pk(1, 0, 0, 15, 15, 15, 15));

    // Mid-window reset with a pending result
    do_reset();
    en15 = 1; sp15 = 4'hf; b15.out_ready = 0;
    for (int i = 0; i < 15; i++) step();
    check("rst_pending", o15, pk(1, 0, 0, 15, 15, 15, 15));
    for (int i = 0; i < 7; i++) step();
    rst_n = 0;
    step();
    check("rst_outputs_zero", o15, '0);
    rst_n = 1;
    for (int i = 0; i < 14; i++) step();
    check("rst_pre_close", o15, '0);
    step();
    check("rst_result", o15, pk(1, 0, 0, 15, 15, 15, 15));

    // WINDOW=1: every enabled edge is a result
    do_reset();
    en1 = 1; b1.out_ready = 1;
    begin
      logic [3:0] seq [3];
      seq[0] = 4'b1010; seq[1] = 4'b0110; seq[2] = 4'b0001;
      for (int i = 0; i < 3; i++) begin
        sp1 = seq[i];
        step();
        check($sformatf("w1[%0d]", i), o1,
              pk(1, 0, 0, {3'b0, seq[i][0]}, {3'b0, seq[i][1]}, {3'b0, seq[i][2]}, {3'b0, seq[i][3]}));
      end
    end
    en1 = 0; sp1 = 4'hf;
    step();
    check("w1_consumed", o1, pk(0, 0, 0, 1, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Four-channel spike-count decoder at the output end of the neuron array. It receives the 4-bit per-cycle spike vector produced by the neuron layer and counts spikes per channel over a fixed window of WINDOW clock cycles. At the end of each window it presents four 4-bit saturating counts through a valid/ready handshake, turning spike trains back into nibble values for readout logic or the next processing stage.

## Interface

Parameters:
- WINDOW, 15: window length in clock cycles; legal range 1..255.
- CW, 4: count width per channel; counts saturate at 2^CW-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  counting enable; low discards the partial window.
- spikes  in  4  spike vector; bit i is channel i+1, sampled every enabled edge.
- cnt1, cnt2, cnt3, cnt4  out  CW each  spike counts of the last completed window.
- sat  out  4  per-channel flag: the true count of the presented window exceeded 2^CW-1.
- out_valid  out  1  result registers hold an unconsumed window result.
- out_ready  in  1  consumer accepts the result at this edge when out_valid=1.
- overrun  out  1  sticky: a completed window was dropped because the previous result was not consumed.

## Operation

- FSM states: IDLE, COUNT.
  - IDLE: accumulators and window counter (win_cnt) held at 0. An edge with en=1 moves to COUNT, and that edge's spikes are counted as sample 0.
  - COUNT: every edge with en=1 adds spikes[i] to acc[i] and increments win_cnt.
  - An edge with en=0 returns to IDLE and clears acc and win_cnt. The partial window is discarded.
- Saturation:
  - An increment while acc[i] = 2^CW-1 leaves acc[i] unchanged and sets the per-channel sat accumulator bit.
  - Accumulators never wrap.
- Window close is the edge with en=1 and win_cnt = WINDOW-1. On this edge:
  - The closing sample is included: final = sat_add(acc, spikes).
  - acc, sat accumulators and win_cnt reset to 0. The FSM stays in COUNT, and the next edge is sample 0 of the next window.
  - If out_valid=0, or out_valid=1 with out_ready=1 on the same edge: cnt1..4 and sat load final, and out_valid is 1.
  - If out_valid=1 and out_ready=0: final is dropped, the output registers stay unchanged, and overrun is set to 1.
- Handshake:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1.
  - If no window close happens on that edge, out_valid goes to 0 and cnt/sat keep their last values.
  - While out_valid=1 and out_ready=0, cnt1..4 and sat are stable.
  - out_ready while out_valid=0 has no effect.
- en does not affect the output registers or the handshake. A pending result stays valid through IDLE.
- overrun clears only on reset.

## Timing

- Reset (rst_n=0 at an edge) sets: state IDLE, acc=0, win_cnt=0, cnt1..4=0, sat=0, out_valid=0, overrun=0. Reset mid-window discards the window.
- Latency: out_valid rises, with the new counts, in the cycle after the closing edge. That is WINDOW enabled edges after the first sample.
- Throughput: one result per WINDOW enabled cycles. Back-to-back results are loss-free if out_ready=1 at or before each window close.
- WINDOW=1: every enabled edge closes a window, and counts are 0 or 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package spike_pkg:
  - state enum {IDLE, COUNT}
  - default WINDOW and CW constants
  - NCH=4 channel count
- Sub-module spike_acc_channel, instantiated 4 times:
  - Ports: clk, rst_n, clr, inc, acc[CW-1:0], sat_bit.
  - Holds one saturating accumulator and its overflow bit.
  - Outputs the next-value used at window close.
- The top level holds the FSM, win_cnt, output registers, handshake and overrun.

## Test plan

- Reset: assert rst_n=0 for 2 edges with random inputs -> cnt1..4=0, sat=0, out_valid=0, overrun=0.
- Full rate: WINDOW=15, en=1, out_ready=1, spikes=4'b1111 constant -> out_valid=1 after the 15th edge, all cnt=15, sat=0. Repeats every 15 cycles.
- Pattern: WINDOW=15, ch1 spikes every cycle, ch2 on even samples 0..14, ch3 never, ch4 only on sample 14 -> cnt1=15, cnt2=8, cnt3=0, cnt4=1.
- Saturation: WINDOW=20, spikes=4'b0101 -> cnt1=15, cnt3=15, cnt2=0, cnt4=0, sat=4'b0101.
- Backpressure: WINDOW=4, spikes=4'b0001, out_ready=0 for 2 windows, window 2 all-zero spikes -> window 1 result (cnt1=4) stays stable and overrun=1 after the 2nd close. Then out_ready=1 for one edge -> out_valid=0 on the next cycle while cnt1 holds 4.
- Enable and mid-window reset:
  - en=1 for 7 samples of 1111, then en=0 for 3 cycles, then en=1 -> the first result appears after 15 further enabled edges with all cnt=15.
  - Repeating with rst_n=0 at sample 7 instead of en=0 -> same result, plus all outputs 0 immediately after reset.
